// File: rtl/midi_burst_pack.sv
// midi_burst_pack: packs five octave/note/velocity slots into MIDI note words,
// one slot per cycle, and publishes the whole burst at once with a ready strobe.
module midi_burst_pack #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             vals_ready_in,
  input  logic [4:0][3:0]  octave_count_in,
  input  logic [4:0][7:0]  note_value_array_in,
  input  logic [4:0][7:0]  note_velocity_array_in,
  output logic [4:0][20:0] midi_burst_data_out,
  output logic [2:0]       on_msg_count_out,
  output logic             only_off_msgs_out,
  output logic             midi_burst_ready_out,
  output logic             busy_out,
  output logic             overrun_out
);
  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0][3:0] oct_r;
  logic [4:0][7:0] val_r, vel_r;
  logic [4:0][20:0] shadow;
  logic [2:0] idx, on_cnt;
  logic any_legal;
  logic [3:0] oct;
  logic [7:0] val, vel;
  logic [8:0] note;
  logic legal;
  logic [20:0] word;
  // 9-bit note keeps the full oct*12+val so out-of-range notes are rejected, not wrapped
  always_comb begin
    oct = oct_r[idx];
    val = val_r[idx];
    vel = vel_r[idx];
    note = {2'b0, oct, 3'b0} + {3'b0, oct, 2'b0} + {1'b0, val};
    legal = (val <= 8'd11) && (note <= 9'd127);
    word = legal ? {vel != 8'd0, CHANNEL, note[7:0], vel} : 21'd0;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = vals_ready_in ? PACK : IDLE;
      PACK: state_nxt = (idx == 3'd4) ? DONE : PACK;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      oct_r <= '0;
      val_r <= '0;
      vel_r <= '0;
      shadow <= '0;
      idx <= '0;
      on_cnt <= '0;
      any_legal <= 1'b0;
      midi_burst_data_out <= '0;
      on_msg_count_out <= '0;
      only_off_msgs_out <= 1'b0;
      midi_burst_ready_out <= 1'b0;
      busy_out <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      midi_burst_ready_out <= 1'b0;
      busy_out <= state_nxt != IDLE;
      if (vals_ready_in && state != IDLE) overrun_out <= 1'b1;
      case (state)
        IDLE: if (vals_ready_in) begin
          oct_r <= octave_count_in;
          val_r <= note_value_array_in;
          vel_r <= note_velocity_array_in;
          idx <= '0;
          on_cnt <= '0;
          any_legal <= 1'b0;
        end
        PACK: begin
          shadow[idx] <= word;
          idx <= idx + 3'd1;
          on_cnt <= on_cnt + {2'b0, legal && (vel != 8'd0)};
          any_legal <= any_legal | legal;
        end
        DONE: begin
          midi_burst_data_out <= shadow;
          on_msg_count_out <= on_cnt;
          only_off_msgs_out <= (on_cnt == 3'd0) && any_legal;
          midi_burst_ready_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
